voxel_fetch_responder: RTL and testbench

//  Serves voxel reads issued by the surface extractor (voxel_addr/voxel_read_en ->

---
 rtl/hydra_voxel_pkg.sv | 12 +
 rtl/voxel_req_fifo.sv | 40 ++++
 rtl/voxel_fetch_responder.sv | 153 +++++++++++++++
 tb/tb_voxel_fetch_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_voxel_pkg.sv
// hydra_voxel_pkg: shared widths, FSM states, request record and range check for the voxel fetch path
package hydra_voxel_pkg;
  localparam int VOXEL_ADDR_W = 18;
  localparam int VOXEL_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, REQ, RESP} voxel_fsm_e;
  typedef struct packed {
    logic [VOXEL_ADDR_W-1:0] addr;
  } voxel_req_t;
  function automatic logic voxel_oor(input logic [VOXEL_ADDR_W-1:0] a, input int unsigned cells);
    return 32'(a) >= cells;
  endfunction
endpackage

// File: rtl/voxel_req_fifo.sv
// voxel_req_fifo: synchronous read-request queue with count-based full/empty flags
module voxel_req_fifo
  import hydra_voxel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  voxel_req_t i_din,
  input  logic       i_pop,
  output voxel_req_t o_dout,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  voxel_req_t    r_mem [DEPTH];
  // pointer and occupancy tracking; push and pop may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  // storage needs no reset; occupancy guards every read of it
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end
  assign o_dout  = r_mem[r_rptr];
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/voxel_fetch_responder.sv
// voxel_fetch_responder: queues voxel reads, arbitrates with writes, drives one req/ack SRAM port with timeout;
// optional one-entry last-read cache enabled by defining VOXEL_LASTHIT_EN
module voxel_fetch_responder
  import hydra_voxel_pkg::*;
#(
  parameter int GRID_SIZE   = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic [VOXEL_ADDR_W-1:0] rd_addr,
  output logic                    rd_ready,
  output logic                    rd_valid,
  output logic [VOXEL_DATA_W-1:0] rd_data,
  output logic                    rd_err,
  input  logic                    wr_en,
  input  logic [VOXEL_ADDR_W-1:0] wr_addr,
  input  logic [VOXEL_DATA_W-1:0] wr_data,
  output logic                    wr_ready,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [VOXEL_ADDR_W-1:0] mem_addr,
  output logic [VOXEL_DATA_W-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [VOXEL_DATA_W-1:0] mem_rdata
);
  localparam int unsigned CELLS = GRID_SIZE ** 3;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  voxel_fsm_e              r_state;
  logic [TW-1:0]           r_timer;
  logic                    r_mem_req, r_mem_we, r_rd_valid, r_rd_err, r_wr_done, r_wr_err;
  logic [VOXEL_ADDR_W-1:0] r_mem_addr;
  logic [VOXEL_DATA_W-1:0] r_mem_wdata, r_rd_data;
  logic                    w_full, w_empty, w_rd_acc, w_wr_acc, w_pop, w_tmo, w_head_oor, w_wr_oor, w_hit;
  logic [VOXEL_DATA_W-1:0] w_hit_data;
  voxel_req_t              w_head;
  assign rd_ready   = !w_full;
  assign wr_ready   = (r_state == IDLE) && w_empty;
  assign w_rd_acc   = rd_en && rd_ready;
  assign w_wr_acc   = wr_en && wr_ready;
  assign w_head_oor = voxel_oor(w_head.addr, CELLS);
  assign w_wr_oor   = voxel_oor(wr_addr, CELLS);
  assign w_tmo      = !mem_ack && (r_timer == TW'(MEM_TIMEOUT - 1));
  // the head entry leaves the queue only when its response is issued
  assign w_pop = !w_empty && ((r_state == IDLE && (w_head_oor || w_hit)) ||
                              (r_state == REQ && !r_mem_we && (mem_ack || w_tmo)));
  voxel_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_rd_acc),
    .i_din  ('{addr: rd_addr}),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
`ifdef VOXEL_LASTHIT_EN
  logic [VOXEL_ADDR_W-1:0] r_c_tag;
  logic [VOXEL_DATA_W-1:0] r_c_data;
  logic                    r_c_valid;
  assign w_hit      = r_c_valid && (r_c_tag == w_head.addr);
  assign w_hit_data = r_c_data;
  // remember the last acked read; any accepted write may change memory, so drop it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_valid <= 1'b0;
      r_c_tag   <= '0;
      r_c_data  <= '0;
    end else if (w_wr_acc) begin
      r_c_valid <= 1'b0;
    end else if (r_state == REQ && mem_ack && !r_mem_we) begin
      r_c_valid <= 1'b1;
      r_c_tag   <= r_mem_addr;
      r_c_data  <= mem_rdata;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif
  // transaction FSM: writes win in IDLE, reads drain from the queue, every request bounded by the timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_err    <= 1'b0;
      r_rd_data   <= '0;
      r_wr_done   <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_wr_acc && w_wr_oor) begin
            r_state   <= RESP;
            r_wr_done <= 1'b1;
            r_wr_err  <= 1'b1;
          end else if (w_wr_acc) begin
            r_state     <= REQ;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= wr_addr;
            r_mem_wdata <= wr_data;
          end else if (!w_empty && (w_head_oor || w_hit)) begin
            r_state    <= RESP;
            r_rd_valid <= 1'b1;
            r_rd_err   <= w_head_oor;
            r_rd_data  <= w_head_oor ? '0 : w_hit_data;
          end else if (!w_empty) begin
            r_state    <= REQ;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_head.addr;
          end
        end
        REQ: begin
          if (mem_ack || w_tmo) begin
            r_state    <= RESP;
            r_mem_req  <= 1'b0;
            r_wr_done  <= r_mem_we;
            r_wr_err   <= r_mem_we ? !mem_ack : r_wr_err;
            r_rd_valid <= !r_mem_we;
            r_rd_err   <= r_mem_we ? r_rd_err : !mem_ack;
            r_rd_data  <= r_mem_we ? r_rd_data : (mem_ack ? mem_rdata : '0);
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_valid  = r_rd_valid;
  assign rd_err    = r_rd_err;
  assign rd_data   = r_rd_data;
  assign wr_done   = r_wr_done;
  assign wr_err    = r_wr_err;
endmodule

// File: tb/tb_voxel_fetch_responder.sv
// tb_voxel_fetch_responder: directed plus randomized checks against a transaction-level scoreboard and an SRAM responder
module tb_voxel_fetch_responder;
  localparam int GS = 32;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0, mem_ack = 1'b0;
  logic [17:0] rd_addr = '0, wr_addr = '0;
  logic [63:0] wr_data = '0, mem_rdata = '0;
  logic        rd_ready, rd_valid, rd_err, wr_ready, wr_done, wr_err, mem_req, mem_we;
  logic [63:0] rd_data, mem_wdata;
  logic [17:0] mem_addr;
  typedef struct packed {
    logic        wr;
    logic        err;
    logic [63:0] data;
  } exp_t;
  exp_t        exp_q[$];
  exp_t        m_e;
  logic [63:0] model [int];
  logic [63:0] sram [int];
  int          n_vec = 0, n_miss = 0, n_mem_rd = 0, n_rd_exp = 0;
  int          ack_min = 0, ack_max = 0, wait_n = 0;
  bit          never_ack = 0, late_ack = 0, in_req = 0, acked = 0, racc;
  logic [17:0] p_addr;
  logic [63:0] p_wdata;
  logic        p_we;
  always #5 clk = ~clk;
  voxel_fetch_responder #(.GRID_SIZE(GS), .FIFO_DEPTH(4), .MEM_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done), .wr_err(wr_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit oor(input logic [17:0] a);
    return int'(a) >= GS * GS * GS;
  endfunction
  function automatic logic [63:0] init_word(input logic [17:0] a);
    return {14'h0, a, 14'h2a5, a};
  endfunction
  function automatic logic [63:0] mdl_rd(input logic [17:0] a);
    return model.exists(int'(a)) ? model[int'(a)] : init_word(a);
  endfunction
  function automatic logic [63:0] sram_rd(input logic [17:0] a);
    return sram.exists(int'(a)) ? sram[int'(a)] : init_word(a);
  endfunction
  // one cycle of stimulus; acceptance is decided from the ready flags visible before the edge
  task automatic step(input bit r, input logic [17:0] ra, input bit w, input logic [17:0] wa, input logic [63:0] wd,
                      output bit ra_ok);
    exp_t e;
    bit   wacc;
    wacc  = w && wr_ready;
    ra_ok = r && rd_ready;
    rd_en = r; rd_addr = ra; wr_en = w; wr_addr = wa; wr_data = wd;
    if (wacc) begin
      e.wr = 1'b1; e.err = oor(wa) || never_ack; e.data = '0;
      exp_q.push_back(e);
      if (!e.err) model[int'(wa)] = wd;
    end
    if (ra_ok) begin
      e.wr = 1'b0; e.err = oor(ra) || never_ack; e.data = e.err ? '0 : mdl_rd(ra);
      exp_q.push_back(e);
      if (!e.err) n_rd_exp++;
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask
  // scoreboard for responses plus an SRAM model that acks after a chosen delay
  always @(negedge clk) begin
    if (!rst_n) begin
      in_req = 0; acked = 0; mem_ack = 1'b0;
      exp_q.delete();
    end else begin
      if (rd_valid) begin
        if (exp_q.size() == 0 || exp_q[0].wr) chk("rd_unexpected", 64'd1, 64'd0);
        else begin
          m_e = exp_q.pop_front();
          chk("rd_data", rd_data, m_e.data);
          chk("rd_err", 64'(rd_err), 64'(m_e.err));
        end
      end
      if (wr_done) begin
        if (exp_q.size() == 0 || !exp_q[0].wr) chk("wr_unexpected", 64'd1, 64'd0);
        else begin
          m_e = exp_q.pop_front();
          chk("wr_err", 64'(wr_err), 64'(m_e.err));
        end
      end
      mem_rdata = {$urandom, $urandom};
      if (!mem_req) begin
        in_req = 0; acked = 0; mem_ack = late_ack;
      end else if (acked) begin
        chk("mem_req_drop", 64'(mem_req), 64'd0);
        acked = 0; mem_ack = 1'b0;
      end else begin
        if (!in_req) begin
          in_req = 1;
          wait_n = $urandom_range(ack_max, ack_min);
          chk("mem_addr_range", 64'(oor(mem_addr)), 64'd0);
        end else begin
          chk("mem_addr_hold", 64'(mem_addr), 64'(p_addr));
          chk("mem_we_hold", 64'(mem_we), 64'(p_we));
          chk("mem_wdata_hold", mem_wdata, p_wdata);
        end
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        mem_ack = 1'b0;
        if (!never_ack) begin
          if (wait_n == 0) begin
            mem_ack = 1'b1; acked = 1;
            if (mem_we) sram[int'(mem_addr)] = mem_wdata;
            else begin
              mem_rdata = sram_rd(mem_addr);
              n_mem_rd++;
            end
          end else wait_n--;
        end
      end
    end
  end
  initial begin
    int cnt, m0, e0;
    logic [17:0] a;
    idle(2);
    chk("reset_outs", 64'({mem_req, rd_valid, wr_done, rd_err, wr_err, rd_ready, wr_ready}), 64'b0000011);
    rst_n = 1'b1;
    idle(1);
    // single read with immediate ack, after seeding the word through a write
    step(0, 0, 1, 18'h00123, 64'hDEADBEEF_0000_0001, racc);
    drain("t1_seed_drain");
    step(1, 18'h00123, 0, 0, 0, racc);
    chk("t1_accept", 64'(racc), 64'd1);
    chk("t1_req_early", 64'(mem_req), 64'd0);
    @(negedge clk);
    chk("t1_req_high", 64'(mem_req), 64'd1);
    @(negedge clk);
    chk("t1_rd_valid", 64'(rd_valid), 64'd1);
    chk("t1_req_1cyc", 64'(mem_req), 64'd0);
    drain("t1_drain");
    // same-cycle write and read to one address: write served first, read sees it
    step(1, 18'h00010, 1, 18'h00010, 64'hA5A5_0010_CAFE_F00D, racc);
    drain("t5_drain");
    // out-of-range read and write
    step(1, 18'd32768, 0, 0, 0, racc);
    drain("t4_rd_drain");
    step(0, 0, 1, 18'd32768, 64'h1234, racc);
    drain("t4_wr_drain");
    // queue fills under a 10-cycle ack stall; fifth read waits for space
    ack_min = 10; ack_max = 10;
    for (int i = 0; i < 4; i++) step(1, 18'h200 + 18'(i), 0, 0, 0, racc);
    chk("t2_full_ready", 64'(rd_ready), 64'd0);
    racc = 0;
    for (int i = 0; i < 100 && !racc; i++) step(1, 18'h204, 0, 0, 0, racc);
    chk("t2_fifth_acc", 64'(racc), 64'd1);
    drain("t2_drain");
    ack_min = 0; ack_max = 0;
    // timeout: request held exactly MEM_TIMEOUT cycles, then a late ack must be ignored
    never_ack = 1;
    step(1, 18'h00077, 0, 0, 0, racc);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (mem_req) cnt++;
      else if (cnt > 0) break;
      @(negedge clk);
    end
    chk("t3_req_cycles", 64'(cnt), 64'd64);
    never_ack = 0;
    late_ack = 1;
    idle(2);
    late_ack = 0;
    idle(4);
    chk("t3_late_ack_req", 64'(mem_req), 64'd0);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    // reset in the middle of a request drops mem_req without waiting for a clock
    never_ack = 1;
    step(1, 18'h00055, 0, 0, 0, racc);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("rst_req_seen", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_req", 64'(mem_req), 64'd0);
    idle(2);
    never_ack = 0;
    rst_n = 1'b1;
    idle(1);
    chk("rst_mid_outs", 64'({mem_req, rd_valid, wr_done, rd_ready, wr_ready}), 64'b00011);
    // repeat read of one address, then write and read again
    step(1, 18'h00040, 0, 0, 0, racc);
    drain("c_first_drain");
    m0 = n_mem_rd;
    step(1, 18'h00040, 0, 0, 0, racc);
    drain("c_second_drain");
`ifdef VOXEL_LASTHIT_EN
    chk("c_second_memrd", 64'(n_mem_rd - m0), 64'd0);
`else
    chk("c_second_memrd", 64'(n_mem_rd - m0), 64'd1);
`endif
    step(0, 0, 1, 18'h00040, 64'h0BAD_0040_0000_0040, racc);
    drain("c_wr_drain");
    m0 = n_mem_rd;
    step(1, 18'h00040, 0, 0, 0, racc);
    drain("c_third_drain");
    chk("c_third_memrd", 64'(n_mem_rd - m0), 64'd1);
    // randomized mix of reads, writes and out-of-range addresses with variable ack delay
    ack_min = 0; ack_max = 4;
    m0 = n_mem_rd; e0 = n_rd_exp;
    for (int i = 0; i < 600; i++) begin
      a = ($urandom % 12 == 0) ? 18'(32768 + $urandom % 200000) : 18'($urandom % 24);
      step($urandom % 3 != 0, a, $urandom % 10 == 0,
           ($urandom % 12 == 0) ? 18'(32768 + $urandom % 200000) : 18'($urandom % 24),
           {$urandom, $urandom}, racc);
    end
    drain("rand_drain");
`ifndef VOXEL_LASTHIT_EN
    chk("rand_memrd_count", 64'(n_mem_rd - m0), 64'(n_rd_exp - e0));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
